half_duplex_serial_codec: RTL and testbench
===========================================

// Module: half_duplex_serial_codec
// PURPOSE
//  Parametrised single-wire half-duplex async serial codec. Successor to the fixed 8N1, 1-clock-per-bit encoder/decoder.
//  Adds: oversampled bit timing, configurable data width, parity, stop bits, RX error flags, TX ready/done handshake.
//  Also adds echo blanking after TX. Sits between the shared rxtx pad and the command/telemetry byte logic.
// PARAMETERS
//  CLKS_PER_BIT   4   clock cycles per serial bit; legal range 1..255 (1 = legacy un-oversampled timing)
//  DATA_BITS      8   data bits per character, LSB first on the wire; legal range 5..9
//  MAX_BYTES      5   characters held by the tx_bytes burst buffer
//  PARITY_MODE    0   0 = none, 1 = even, 2 = odd
//  STOP_BITS      1   stop bits, 1 or 2
//  GUARD_BITS     2   bit periods during which RX stays blanked after tx_switch falls
// PORTS
//  clock          in     1                       system clock
//  reset          in     1                       synchronous, active-high
//  rxtx           inout  1                       shared line; driven only while tx_switch=1, else 'z
//  tx_bytes       in     MAX_BYTES*DATA_BITS     burst; the most-significant character is sent first
//  tx_num_bytes   in     4                       characters to send; values above MAX_BYTES are clamped to MAX_BYTES
//  tx_valid       in     1                       burst request
//  tx_ready       out    1                       high when the block can accept a burst
//  tx_done        out    1                       1-cycle pulse after the last stop bit of a burst
//  tx_switch      out    1                       line-drive enable (output-enable for the pad)
//  rx_byte        out    DATA_BITS               last received character
//  rx_valid       out    1                       1-cycle pulse; rx_byte and both error flags are valid in that cycle
//  rx_frame_err   out    1                       stop bit sampled low (valid with rx_valid)
//  rx_parity_err  out    1                       parity mismatch; always 0 when PARITY_MODE=0
// BEHAVIOUR
//  Reset values:
//   - tx_ready=1, tx_switch=0, line drive=1, all other outputs 0.
//   - Both FSMs go to IDLE; counters clear.
//   - A reset asserted mid-frame releases the line at the same edge. No tx_done is generated.
//  Bit timer: a counter per FSM counts 0..CLKS_PER_BIT-1; a bit boundary occurs at wrap.
//  TX handshake:
//   - A burst is accepted on tx_valid & tx_ready. At that edge tx_bytes and the clamped count are latched, and tx_ready drops.
//   - tx_valid while tx_ready=0 is ignored (not queued).
//   - tx_num_bytes=0 is accepted: tx_done pulses on the next cycle, the line is never driven, and tx_ready returns one cycle later.
//  TX FSM: IDLE -> START -> DATA(DATA_BITS) -> [PARITY] -> STOP(STOP_BITS) -> START for the next character, or DONE.
//   - Each state lasts CLKS_PER_BIT cycles per bit. There is no idle gap between characters.
//   - tx_switch rises with the start bit and stays high through the last stop bit of the burst.
//   - Exit from DONE: tx_done pulses, tx_switch falls, and the guard timer starts. tx_ready rises the cycle after tx_done.
//  Line output is registered. Latency from the accept edge to the start bit on rxtx is 1 cycle.
//  RX input path:
//   - rx_in is the 2-flop synchronised rxtx, forced to 1 while tx_switch=1 or the guard is active.
//   - The guard lasts GUARD_BITS*CLKS_PER_BIT cycles.
//  RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - A falling edge of rx_in in IDLE enters START.
//   - rx_in is sampled at mid-bit (count = CLKS_PER_BIT/2, integer division).
//   - If the start bit is high at mid-bit, the character is a glitch: return to IDLE, no rx_valid.
//   - The stop check uses the first stop bit only. rx_valid pulses at the first-stop-bit sample.
//   - The FSM returns to IDLE at that sample, so back-to-back characters are received.
//   - A frame error still delivers rx_byte. A character in progress when tx_switch rises is abandoned silently.
//  Parity is computed over the DATA_BITS data bits: even parity gives ^data, odd parity gives ~^data.
// STRUCTURE
//  Package half_duplex_serial_pkg holds:
//   - PARITY_NONE/EVEN/ODD constants
//   - TX and RX state encodings
//   - the clog2 helper for counter widths
//  Sub-module serial_rx_frame contains the synchroniser, RX FSM and error flags.
//  The top level contains the TX FSM, burst buffer, guard timer, blanking and tristate.
// TESTING
//  1. Defaults, tx_bytes=0xA5_3C_..., tx_num_bytes=2:
//     - Line shows 0,1,0,1,0,0,1,0,1,1 (each 4 clocks), then 0x3C, with no gap.
//     - tx_switch is high for 80 cycles; tx_done pulses once.
//  2. Loop back an external 0x5A frame at 4 clocks/bit: rx_valid pulses once, rx_byte=0x5A, both error flags are 0.
//  3. PARITY_MODE=1: send 0x07 with the parity bit flipped -> rx_parity_err=1, rx_byte=0x07.
//     - Separately, a stop bit held low -> rx_frame_err=1.
//  4. A 1-clock low glitch on the idle line -> no rx_valid. A line low during tx_switch or the guard window -> no rx_valid.
//  5. tx_valid pulsed while busy: ignored. tx_num_bytes=0: tx_done with no drive. tx_num_bytes=9: exactly 5 characters sent.
//  6. Reset asserted mid-character (TX and RX): tx_switch=0 on the next edge, no rx_valid or tx_done, and a clean frame works afterwards.

Source files
------------

// File: rtl/half_duplex_serial_pkg.sv
// Shared constants, FSM encodings and helpers for the half-duplex serial codec.
package half_duplex_serial_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        TxIdle, TxStart, TxData, TxParity, TxStop, TxDone
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxParity, RxStop
    } rx_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

    // Characters are at most 9 bits; zero-extension leaves the XOR unchanged.
    function automatic logic parity_of(input logic [15:0] data, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/serial_rx_frame.sv
// Receive side: line synchroniser with blanking, mid-bit sampling FSM and error flags.
module serial_rx_frame
    import half_duplex_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = PARITY_NONE
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_line,
    input  logic                 i_blank,
    input  logic                 i_abort,
    output logic [DATA_BITS-1:0] o_byte,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = (DATA_BITS > 1) ? clog2(DATA_BITS) : 1;
    localparam int unsigned Half = CLKS_PER_BIT / 2;

    logic                 r_sync1, r_sync2, r_rx_prev;
    rx_state_e            r_state, w_state_d;
    logic [CntW-1:0]      r_cnt, w_cnt_d;
    logic [BitW-1:0]      r_bit, w_bit_d;
    logic [DATA_BITS-1:0] r_shift, w_shift_d;
    logic                 r_par_bit, w_par_bit_d;
    logic [DATA_BITS-1:0] r_byte, w_byte_d;
    logic                 r_valid, w_valid_d;
    logic                 r_frame_err, w_frame_err_d;
    logic                 r_parity_err, w_parity_err_d;
    logic                 w_rx_in, w_fall, w_mid;

    assign w_rx_in = i_blank ? 1'b1 : r_sync2;
    assign w_fall  = r_rx_prev & ~w_rx_in;
    assign w_mid   = (r_cnt == CntW'(Half));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_state      <= RxIdle;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_byte       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_sync1      <= i_line;
            r_sync2      <= r_sync1;
            r_rx_prev    <= w_rx_in;
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_bit        <= w_bit_d;
            r_shift      <= w_shift_d;
            r_par_bit    <= w_par_bit_d;
            r_byte       <= w_byte_d;
            r_valid      <= w_valid_d;
            r_frame_err  <= w_frame_err_d;
            r_parity_err <= w_parity_err_d;
        end
    end

    // The fall cycle is cycle 0 of the start bit; with one clock per bit it is also its mid-point.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_bit_d     = r_bit;
        w_shift_d   = r_shift;
        w_par_bit_d = r_par_bit;
        if (r_state != RxIdle) begin
            w_cnt_d = (r_cnt == CntW'(CLKS_PER_BIT - 1)) ? '0 : r_cnt + 1'b1;
        end
        case (r_state)
            RxIdle: begin
                if (w_fall) begin
                    w_state_d = (Half == 0) ? RxData : RxStart;
                    w_cnt_d   = (CLKS_PER_BIT > 1) ? CntW'(1) : '0;
                    w_bit_d   = '0;
                end
            end
            RxStart: begin
                if (w_mid) begin
                    w_state_d = w_rx_in ? RxIdle : RxData;
                    w_bit_d   = '0;
                end
            end
            RxData: begin
                if (w_mid) begin
                    w_shift_d = {w_rx_in, r_shift[DATA_BITS-1:1]};
                    if (r_bit == BitW'(DATA_BITS - 1)) begin
                        w_state_d = (PARITY_MODE != PARITY_NONE) ? RxParity : RxStop;
                    end else begin
                        w_bit_d = r_bit + 1'b1;
                    end
                end
            end
            RxParity: begin
                if (w_mid) begin
                    w_par_bit_d = w_rx_in;
                    w_state_d   = RxStop;
                end
            end
            RxStop: begin
                if (w_mid) begin
                    w_state_d = RxIdle;
                end
            end
            default: w_state_d = RxIdle;
        endcase
        if (i_abort) begin
            w_state_d = RxIdle;
        end
    end

    always_comb begin
        w_valid_d      = (r_state == RxStop) && w_mid && !i_abort;
        w_byte_d       = r_byte;
        w_frame_err_d  = r_frame_err;
        w_parity_err_d = r_parity_err;
        if (w_valid_d) begin
            w_byte_d       = r_shift;
            w_frame_err_d  = ~w_rx_in;
            w_parity_err_d = (PARITY_MODE != PARITY_NONE) &&
                             (parity_of(16'(r_shift), PARITY_MODE) != r_par_bit);
        end
    end

    assign o_byte       = r_byte;
    assign o_valid      = r_valid;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;

endmodule

// File: rtl/half_duplex_serial_codec.sv
// Half-duplex single-wire codec: burst transmitter, echo guard, pad tristate and RX instance.
module half_duplex_serial_codec
    import half_duplex_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned MAX_BYTES    = 5,
    parameter int unsigned PARITY_MODE  = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned GUARD_BITS   = 2
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    inout  wire                            io_rxtx,
    input  logic [MAX_BYTES*DATA_BITS-1:0] i_tx_bytes,
    input  logic [3:0]                     i_tx_num_bytes,
    input  logic                           i_tx_valid,
    output logic                           o_tx_ready,
    output logic                           o_tx_done,
    output logic                           o_tx_switch,
    output logic [DATA_BITS-1:0]           o_rx_byte,
    output logic                           o_rx_valid,
    output logic                           o_rx_frame_err,
    output logic                           o_rx_parity_err
);

    localparam int unsigned BufW        = MAX_BYTES * DATA_BITS;
    localparam int unsigned CntW        = (CLKS_PER_BIT > 1) ? clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW        = (DATA_BITS > 1) ? clog2(DATA_BITS) : 1;
    localparam int unsigned CharW       = clog2(MAX_BYTES + 1);
    localparam int unsigned GuardCycles = GUARD_BITS * CLKS_PER_BIT;
    localparam int unsigned GuardW      = (GuardCycles > 0) ? clog2(GuardCycles + 1) : 1;

    tx_state_e            r_state, w_state_d;
    logic [CntW-1:0]      r_cnt, w_cnt_d;
    logic [BitW-1:0]      r_bit, w_bit_d;
    logic [CharW-1:0]     r_chars, w_chars_d;
    logic [BufW-1:0]      r_buf, w_buf_d;
    logic                 r_line, w_line_d;
    logic                 r_switch, w_switch_d;
    logic [GuardW-1:0]    r_guard;
    logic                 w_tick, w_blank;
    logic [CharW-1:0]     w_num_clamped;
    logic [DATA_BITS-1:0] w_top_d;

    assign w_tick  = (r_cnt == CntW'(CLKS_PER_BIT - 1));
    assign w_top_d = w_buf_d[BufW-1 -: DATA_BITS];
    assign w_blank = r_switch | (r_guard != '0);

    always_comb begin
        if (32'(i_tx_num_bytes) > MAX_BYTES) begin
            w_num_clamped = CharW'(MAX_BYTES);
        end else begin
            w_num_clamped = CharW'(i_tx_num_bytes);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= TxIdle;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_chars  <= '0;
            r_buf    <= '0;
            r_line   <= 1'b1;
            r_switch <= 1'b0;
            r_guard  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_bit    <= w_bit_d;
            r_chars  <= w_chars_d;
            r_buf    <= w_buf_d;
            r_line   <= w_line_d;
            r_switch <= w_switch_d;
            if (r_switch && !w_switch_d) begin
                r_guard <= GuardW'(GuardCycles);
            end else if (r_guard != '0) begin
                r_guard <= r_guard - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_bit_d   = r_bit;
        w_chars_d = r_chars;
        w_buf_d   = r_buf;
        if (r_state != TxIdle && r_state != TxDone) begin
            w_cnt_d = w_tick ? '0 : r_cnt + 1'b1;
        end
        case (r_state)
            TxIdle: begin
                if (i_tx_valid) begin
                    w_buf_d   = i_tx_bytes;
                    w_chars_d = w_num_clamped;
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                    w_state_d = (w_num_clamped == '0) ? TxDone : TxStart;
                end
            end
            TxStart: begin
                if (w_tick) begin
                    w_state_d = TxData;
                    w_bit_d   = '0;
                end
            end
            TxData: begin
                if (w_tick) begin
                    if (r_bit == BitW'(DATA_BITS - 1)) begin
                        w_bit_d   = '0;
                        w_state_d = (PARITY_MODE != PARITY_NONE) ? TxParity : TxStop;
                    end else begin
                        w_bit_d = r_bit + 1'b1;
                    end
                end
            end
            TxParity: begin
                if (w_tick) begin
                    w_state_d = TxStop;
                    w_bit_d   = '0;
                end
            end
            TxStop: begin
                if (w_tick) begin
                    if (r_bit == BitW'(STOP_BITS - 1)) begin
                        w_bit_d   = '0;
                        w_chars_d = r_chars - 1'b1;
                        w_buf_d   = r_buf << DATA_BITS;
                        w_state_d = (r_chars == CharW'(1)) ? TxDone : TxStart;
                    end else begin
                        w_bit_d = r_bit + 1'b1;
                    end
                end
            end
            TxDone:  w_state_d = TxIdle;
            default: w_state_d = TxIdle;
        endcase
    end

    // Line and drive enable are registered from the next state so the pad sees flop outputs.
    always_comb begin
        w_line_d   = 1'b1;
        w_switch_d = 1'b1;
        case (w_state_d)
            TxStart:  w_line_d = 1'b0;
            TxData:   w_line_d = w_top_d[w_bit_d];
            TxParity: w_line_d = parity_of(16'(w_top_d), PARITY_MODE);
            TxStop:   w_line_d = 1'b1;
            default:  w_switch_d = 1'b0;
        endcase
    end

    assign o_tx_ready  = (r_state == TxIdle);
    assign o_tx_done   = (r_state == TxDone);
    assign o_tx_switch = r_switch;
    assign io_rxtx     = r_switch ? r_line : 1'bz;

    serial_rx_frame #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY_MODE  (PARITY_MODE)
    ) u_rx (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_line       (io_rxtx),
        .i_blank      (w_blank),
        .i_abort      (r_switch),
        .o_byte       (o_rx_byte),
        .o_valid      (o_rx_valid),
        .o_frame_err  (o_rx_frame_err),
        .o_parity_err (o_rx_parity_err)
    );

endmodule

// File: tb/tb_half_duplex_serial_codec.sv
// Bench: default codec for TX/RX/guard/reset behaviour plus an even-parity instance for RX errors.
module tb_half_duplex_serial_codec;

    localparam int Cpb = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        line0, line1;
    logic [39:0] tx_bytes;
    logic [3:0]  tx_num;
    logic        tx_valid;
    wire         rxtx0, rxtx1;

    logic       ready0, done0, sw0, rx_valid0, fe0, pe0;
    logic [7:0] rx_byte0;
    logic       ready1, done1, sw1, rx_valid1, fe1, pe1;
    logic [7:0] rx_byte1;

    // The far-end device drives the line whenever the codec releases it.
    assign rxtx0 = sw0 ? 1'bz : line0;
    assign rxtx1 = sw1 ? 1'bz : line1;

    half_duplex_serial_codec u_dut (
        .i_clock         (clk),
        .i_reset         (reset),
        .io_rxtx         (rxtx0),
        .i_tx_bytes      (tx_bytes),
        .i_tx_num_bytes  (tx_num),
        .i_tx_valid      (tx_valid),
        .o_tx_ready      (ready0),
        .o_tx_done       (done0),
        .o_tx_switch     (sw0),
        .o_rx_byte       (rx_byte0),
        .o_rx_valid      (rx_valid0),
        .o_rx_frame_err  (fe0),
        .o_rx_parity_err (pe0)
    );

    half_duplex_serial_codec #(.PARITY_MODE(1)) u_dut_par (
        .i_clock         (clk),
        .i_reset         (reset),
        .io_rxtx         (rxtx1),
        .i_tx_bytes      (40'd0),
        .i_tx_num_bytes  (4'd0),
        .i_tx_valid      (1'b0),
        .o_tx_ready      (ready1),
        .o_tx_done       (done1),
        .o_tx_switch     (sw1),
        .o_rx_byte       (rx_byte1),
        .o_rx_valid      (rx_valid1),
        .o_rx_frame_err  (fe1),
        .o_rx_parity_err (pe1)
    );

    int n_checks;
    int n_pass;
    int done_total;
    logic [9:0] got0[$], got1[$], exp0[$], exp1[$];

    always @(negedge clk) begin
        if (rx_valid0) got0.push_back({fe0, pe0, rx_byte0});
        if (rx_valid1) got1.push_back({fe1, pe1, rx_byte1});
        if (done0) done_total++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) line1 = v;
        else line0 = v;
    endtask

    // Reference frame: start 0, data LSB first, even parity (instance 1 only), stop.
    task automatic rx_drive(input bit sel, input logic [7:0] data, input bit bad, input bit flip);
        set_line(sel, 1'b0);
        repeat (Cpb) tick();
        for (int i = 0; i < 8; i++) begin
            set_line(sel, data[i]);
            repeat (Cpb) tick();
        end
        if (sel) begin
            set_line(sel, (^data) ^ flip);
            repeat (Cpb) tick();
        end
        set_line(sel, !bad);
        repeat (Cpb) tick();
        if (bad) begin
            set_line(sel, 1'b1);
            repeat (Cpb) tick();
        end
        if (sel) exp1.push_back({bad, flip, data});
        else exp0.push_back({bad, 1'b0, data});
    endtask

    task automatic rx_check();
        repeat (12) tick();
        check_val("rx0 count", got0.size(), exp0.size());
        check_val("rx1 count", got1.size(), exp1.size());
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) check_val("rx0 char", got0[i], exp0[i]);
        for (int i = 0; i < got1.size() && i < exp1.size(); i++) check_val("rx1 char", got1[i], exp1[i]);
        got0.delete(); exp0.delete(); got1.delete(); exp1.delete();
    endtask

    task automatic send_burst(input logic [39:0] bytes, input logic [3:0] num,
                              input bit poke_busy, input bit poke_guard);
        int n, done_at, sw_cycles, dones, rx_before, waited;
        logic [9:0] obs;
        logic [7:0] ch;
        n = (num > 4'd5) ? 5 : int'(num);
        waited = 0;
        while (!ready0 && waited < 200) begin
            tick();
            waited++;
        end
        check_val("tx ready before burst", ready0, 1);
        rx_before = got0.size();
        tx_bytes = bytes;
        tx_num = num;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_bytes = ~bytes;
        done_at = -1; sw_cycles = 0; dones = 0; obs = '0;
        for (int cyc = 0; cyc < n * 40 + 12; cyc++) begin
            if (cyc < n * 40 && cyc % 4 == 2) obs[(cyc / 4) % 10] = rxtx0;
            if (cyc < n * 40 && cyc % 40 == 38) begin
                ch = bytes[39 - 8 * (cyc / 40) -: 8];
                check_val("tx frame", obs, {1'b1, ch, 1'b0});
            end
            if (sw0) sw_cycles++;
            if (done0) begin
                dones++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at >= 0 && cyc == done_at) check_val("tx ready during done", ready0, 0);
            if (done_at >= 0 && cyc == done_at + 1) check_val("tx ready after done", ready0, 1);
            if (poke_busy && cyc == 6) begin
                tx_valid = 1'b1;
                tx_num = 4'd3;
            end
            if (poke_busy && cyc == 7) tx_valid = 1'b0;
            if (poke_guard && done_at >= 0 && cyc == done_at + 1) line0 = 1'b0;
            if (poke_guard && done_at >= 0 && cyc == done_at + 4) line0 = 1'b1;
            tick();
        end
        check_val("tx done timing", done_at, n * 40);
        check_val("tx done pulses", dones, 1);
        check_val("tx switch cycles", sw_cycles, n * 40);
        repeat (30) tick();
        check_val("tx echo and guard blanked", got0.size(), rx_before);
        check_val("tx idle switch", sw0, 0);
    endtask

    initial begin
        logic [39:0] rb;
        logic [7:0]  rd;
        bit          rsel, rbad, rflip;
        int          done_before;
        n_checks = 0; n_pass = 0; done_total = 0;
        reset = 1'b1; line0 = 1'b1; line1 = 1'b1;
        tx_bytes = '0; tx_num = '0; tx_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_val("reset tx_ready", ready0, 1);
        check_val("reset tx_switch", sw0, 0);
        check_val("reset tx_done", done0, 0);
        check_val("reset rx_valid", rx_valid0, 0);
        check_val("reset rx_byte", rx_byte0, 0);
        check_val("reset frame_err", fe0, 0);
        check_val("reset parity_err", pe0, 0);
        check_val("reset line", rxtx0, 1);

        send_burst(40'hA5_3C_00_00_00, 4'd2, 1'b0, 1'b1);
        send_burst(40'h81_7E_00_FF_55, 4'd9, 1'b0, 1'b0);
        send_burst(40'h12_34_56_78_9A, 4'd1, 1'b1, 1'b0);
        send_burst(40'hDE_AD_BE_EF_01, 4'd0, 1'b0, 1'b0);

        rx_drive(1'b0, 8'h5A, 1'b0, 1'b0);
        rx_check();
        rx_drive(1'b1, 8'h07, 1'b0, 1'b1);
        rx_drive(1'b1, 8'h07, 1'b0, 1'b0);
        rx_drive(1'b1, 8'hC4, 1'b1, 1'b0);
        rx_check();

        line0 = 1'b0;
        tick();
        line0 = 1'b1;
        repeat (20) tick();
        rx_check();

        for (int k = 0; k < 5; k++) begin
            rb = {$urandom(), $urandom()};
            send_burst(rb, 4'($urandom_range(0, 9)), 1'b0, 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            rd = 8'($urandom());
            rsel = 1'($urandom_range(0, 1));
            rbad = ($urandom_range(0, 3) == 0);
            rflip = rsel && ($urandom_range(0, 1) == 1);
            rx_drive(rsel, rd, rbad, rflip);
        end
        rx_check();

        // Reset while both a TX burst and an RX character are in flight.
        done_before = done_total;
        tx_bytes = 40'hC3_81_00_00_00;
        tx_num = 4'd2;
        tx_valid = 1'b1;
        line1 = 1'b0;
        tick();
        tx_valid = 1'b0;
        repeat (3) tick();
        line1 = 1'b1;
        repeat (10) tick();
        check_val("tx switch before reset", sw0, 1);
        reset = 1'b1;
        tick();
        check_val("reset mid-frame switch", sw0, 0);
        check_val("reset mid-frame line", rxtx0, 1);
        check_val("reset mid-frame ready", ready0, 1);
        reset = 1'b0;
        repeat (100) tick();
        check_val("no tx_done after reset", done_total, done_before);
        rx_check();

        send_burst(40'h3C_A5_00_00_00, 4'd2, 1'b0, 1'b0);
        rx_drive(1'b1, 8'h96, 1'b0, 1'b0);
        rx_drive(1'b0, 8'h69, 1'b0, 1'b0);
        rx_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
